nibble_serial_adder_seq: RTL and testbench

- Sequencer around the team's 4-bit ripple-carry adder for operands wider than 4 bits.
- Accepts a pair of WORDS-nibble operands, then drives one nibble pair per cycle into an external 4-bit adder instance.
- Collects each 4-bit sum and chains the carry through a register.
- Returns the full-width sum and the final carry over a valid/ready handshake.

---
 rtl/nibble_serial_adder_seq.sv | 133 +++++++++++++
 tb/tb_nibble_serial_adder_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_seq.sv
// Serial sequencer that adds two WORDS-nibble operands one slice per cycle through an external
// 4-bit adder. Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*WORDS-1:0] in_a,
  input  logic [4*WORDS-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*WORDS-1:0] out_sum,
  output logic               out_cout,
  output logic [3:0]         add_a,
  output logic [3:0]         add_b,
  output logic               add_cin,
  input  logic [3:0]         add_sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  input  logic               add_cout,
  output logic               out_ovf
`else
  input  logic               add_cout
`endif
);

  localparam int unsigned Width = 4 * WORDS;
  localparam int unsigned IdxW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [IdxW-1:0]   r_idx;
  logic              r_carry;
  logic [Width-1:0]  r_a;
  logic [Width-1:0]  r_b;
  logic [Width-1:0]  r_sum;
  logic [3:0]        w_a_nib;
  logic [3:0]        w_b_nib;
  logic              w_accept;
  logic              w_last;

  assign w_accept = (r_state == StIdle) && in_valid;
  assign w_last   = (r_idx == LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Slice select from the registered operands.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (r_idx == IdxW'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
    out_sum   = (r_state == StDone) ? r_sum : '0;
    out_cout  = (r_state == StDone) ? r_carry : 1'b0;
    add_a     = (r_state == StRun) ? w_a_nib : 4'h0;
    add_b     = (r_state == StRun) ? w_b_nib : 4'h0;
    add_cin   = (r_state == StRun) ? r_carry : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_carry <= in_cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (r_state == StRun) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        if (r_idx == IdxW'(i)) begin
          r_sum[4*i +: 4] <= add_sum;
        end
      end
      r_carry <= add_cout;
      if (!w_last) begin
        r_idx <= r_idx + IdxW'(1);
      end
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Carry into the top bit is recovered from its sum bit and the operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if ((r_state == StRun) && w_last) begin
      r_ovf <= w_a_nib[3] ^ w_b_nib[3] ^ add_sum[3] ^ add_cout;
    end
  end

  assign out_ovf = (r_state == StDone) ? r_ovf : 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Directed self-checking bench for nibble_serial_adder_seq (WORDS=4); the bench models the
// external 4-bit adder combinationally.
module tb_nibble_serial_adder_seq;

  localparam int unsigned WORDS = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        out_ovf;
`endif

  int checks;
  int failures;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  nibble_serial_adder_seq #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .add_cout (add_cout),
    .out_ovf  (out_ovf)
`else
    .add_cout (add_cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair, waits (bounded) for out_valid; leaves the result unacknowledged.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        output logic [3:0] cins, output int lat);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    cins     = '0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) cins[lat] = add_cin;
      tick();
      lat++;
    end
  endtask

  logic [3:0]  cins;
  int          lat;
  logic [15:0] held;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    chk("rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 0x1234 + 0x4321
    run_op(16'h1234, 16'h4321, 1'b0, cins, lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_sum", 32'(out_sum), 32'h5555);
    chk("t1_cout", 32'(out_cout), 32'd0);
    chk("t1_in_ready_busy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_in_ready_back", 32'(in_ready), 32'd1);

    // 0xFFFF + 0x0001: carry ripples through every slice
    run_op(16'hFFFF, 16'h0001, 1'b0, cins, lat);
    chk("t2_latency", 32'(lat), 32'd4);
    chk("t2_cins", 32'(cins), 32'b1110);
    chk("t2_sum", 32'(out_sum), 32'h0000);
    chk("t2_cout", 32'(out_cout), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 0 + 0 + cin, then stall the consumer with new operands offered
    run_op(16'h0000, 16'h0000, 1'b1, cins, lat);
    chk("t3_sum", 32'(out_sum), 32'h0001);
    chk("t3_cout", 32'(out_cout), 32'd0);
    held     = out_sum;
    in_a     = 16'hABCD;
    in_b     = 16'h1111;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_sum", 32'(out_sum), 32'(held));
      chk("t3_stall_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_release_valid", 32'(out_valid), 32'd0);
    tick();
    chk("t3_no_stray_accept", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held high
    in_a     = 16'h00FF;
    in_b     = 16'h0001;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_a = 16'h8000;
    in_b = 16'h8000;
    lat  = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("b2b_first_latency", 32'(lat), 32'd4);
    chk("b2b_first_sum", 32'(out_sum), 32'h0100);
    chk("b2b_first_cout", 32'(out_cout), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("b2b_second_latency", 32'(lat), 32'd4);
    chk("b2b_second_sum", 32'(out_sum), 32'h0000);
    chk("b2b_second_cout", 32'(out_cout), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset after two RUN cycles
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_outs", 32'({out_sum, out_cout}), 32'd0);
    chk("mid_rst_add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_valid", 32'(out_valid), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, cins, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_sum", 32'(out_sum), 32'h0002);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, cins, lat);
    chk("ovf_pos_flag", 32'(out_ovf), 32'd1);
    chk("ovf_pos_cout", 32'(out_cout), 32'd0);
    chk("ovf_pos_sum", 32'(out_sum), 32'h8000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run_op(16'hFFFF, 16'h0001, 1'b0, cins, lat);
    chk("ovf_wrap_flag", 32'(out_ovf), 32'd0);
    chk("ovf_wrap_cout", 32'(out_cout), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
